// File: rtl/dmem_arbiter_pkg.sv
// dmem_pkg: shared definitions for the data-memory arbiter slice.
//   - state_t   : arbiter FSM encoding (IDLE/ACCESS/RESP)
//   - PORT_CPU  : requester index of the CPU load/store path
//   - PORT_DBG  : requester index of the debug/loader path
//   - *_DEF     : default widths and memory depth
package dmem_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DEPTH_DEF  = 32;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundles both requester channels and the memory strobes.
//   reqN_valid/ready/write/addr/wdata : request channel of port N (0 = CPU, 1 = debug)
//   rspN_valid/rdata/err              : response channel of port N
//   mem_write/read/address/wdata      : strobes towards the data memory
//   mem_rdata                         : registered read data from the memory
// Modports: master = requesters + memory side, slave = the arbiter.
interface dmem_arbiter_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
);
    logic              req0_valid;
    logic              req0_ready;
    logic              req0_write;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              rsp0_valid;
    logic [DATA_W-1:0] rsp0_rdata;
    logic              rsp0_err;

    logic              req1_valid;
    logic              req1_ready;
    logic              req1_write;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              rsp1_valid;
    logic [DATA_W-1:0] rsp1_rdata;
    logic              rsp1_err;

    logic              mem_write;
    logic              mem_read;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output req0_valid, req0_write, req0_addr, req0_wdata,
        input  req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
        output req1_valid, req1_write, req1_addr, req1_wdata,
        input  req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
        input  mem_write, mem_read, mem_address, mem_wdata,
        output mem_rdata
    );

    modport slave (
        input  req0_valid, req0_write, req0_addr, req0_wdata,
        output req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
        input  req1_valid, req1_write, req1_addr, req1_wdata,
        output req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
        output mem_write, mem_read, mem_address, mem_wdata,
        input  mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2: combinational 2-way round-robin picker.
//   valid_i      : request present per port
//   last_grant_i : port granted most recently
//   grant_o      : one-hot winner (all zero when nothing is valid)
module rr_arb2 (
    input  logic [1:0] valid_i,
    input  logic       last_grant_i,
    output logic [1:0] grant_o
);
    // On a tie the port that did not win last time goes first.
    always_comb begin
        grant_o    = '0;
        grant_o[0] = valid_i[0] & (~valid_i[1] | last_grant_i);
        grant_o[1] = valid_i[1] & (~valid_i[0] | ~last_grant_i);
    end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter sharing a single-port data memory between
// the CPU path (port 0) and the debug/loader path (port 1). Each accepted
// request becomes one single-cycle memory strobe followed by one response pulse.
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : dmem_arbiter_if.slave (request/response channels + memory strobes)
// Optional: define DMEM_ADDR_CHECK_EN to suppress memory access for addresses
// >= DEPTH and flag them with rspN_err.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF
) (
    input  logic          clk,
    input  logic          reset,
    dmem_arbiter_if.slave bus
);
`ifdef DMEM_ADDR_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              cmd_write_q, cmd_write_d;
    logic              cmd_port_q, cmd_port_d;
    logic              cmd_err_q, cmd_err_d;
    logic              mem_write_q, mem_write_d;
    logic              mem_read_q, mem_read_d;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [1:0]        rsp_valid_q, rsp_valid_d;
    logic [1:0]        rsp_err_q, rsp_err_d;

    logic [1:0]        req_valid;
    logic [1:0]        grant;
    logic              sel_write;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_err;
    logic [1:0]        rsp_rd_en;

    assign req_valid = {bus.req1_valid, bus.req0_valid};

    rr_arb2 u_rr_arb2 (
        .valid_i      (req_valid),
        .last_grant_i (last_grant_q),
        .grant_o      (grant)
    );

    always_comb begin
        sel_write = grant[1] ? bus.req1_write : bus.req0_write;
        sel_addr  = grant[1] ? bus.req1_addr  : bus.req0_addr;
        sel_wdata = grant[1] ? bus.req1_wdata : bus.req0_wdata;
        sel_err   = CHECK_EN && (sel_addr >= ADDR_W'(DEPTH));
    end

    // Memory strobes and response flags are computed one state ahead so the
    // outputs come straight from flops during ACCESS and RESP.
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        cmd_write_d   = cmd_write_q;
        cmd_port_d    = cmd_port_q;
        cmd_err_d     = cmd_err_q;
        mem_write_d   = 1'b0;
        mem_read_d    = 1'b0;
        mem_address_d = '0;
        mem_wdata_d   = '0;
        rsp_valid_d   = '0;
        rsp_err_d     = '0;
        unique case (state_q)
            IDLE: begin
                if (|grant) begin
                    cmd_write_d   = sel_write;
                    cmd_port_d    = grant[1];
                    cmd_err_d     = sel_err;
                    last_grant_d  = grant[1];
                    mem_write_d   = sel_write & ~sel_err;
                    mem_read_d    = ~sel_write & ~sel_err;
                    mem_address_d = sel_addr;
                    mem_wdata_d   = sel_wdata;
                    state_d       = ACCESS;
                end
            end
            ACCESS: begin
                rsp_valid_d[cmd_port_q] = 1'b1;
                rsp_err_d[cmd_port_q]   = cmd_err_q;
                state_d                 = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            last_grant_q  <= PORT_DBG;
            cmd_write_q   <= 1'b0;
            cmd_port_q    <= PORT_CPU;
            cmd_err_q     <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_address_q <= '0;
            mem_wdata_q   <= '0;
            rsp_valid_q   <= '0;
            rsp_err_q     <= '0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            cmd_write_q   <= cmd_write_d;
            cmd_port_q    <= cmd_port_d;
            cmd_err_q     <= cmd_err_d;
            mem_write_q   <= mem_write_d;
            mem_read_q    <= mem_read_d;
            mem_address_q <= mem_address_d;
            mem_wdata_q   <= mem_wdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_err_q     <= rsp_err_d;
        end
    end

    // Read data comes straight from the memory's output register during RESP.
    assign rsp_rd_en = rsp_valid_q & {2{~cmd_write_q & ~cmd_err_q}};

    // Ready is gated by reset so every output is low while reset is held.
    assign bus.req0_ready = reset && (state_q == IDLE) && grant[PORT_CPU];
    assign bus.req1_ready = reset && (state_q == IDLE) && grant[PORT_DBG];

    assign bus.rsp0_valid = rsp_valid_q[PORT_CPU];
    assign bus.rsp1_valid = rsp_valid_q[PORT_DBG];
    assign bus.rsp0_err   = rsp_err_q[PORT_CPU];
    assign bus.rsp1_err   = rsp_err_q[PORT_DBG];
    assign bus.rsp0_rdata = rsp_rd_en[PORT_CPU] ? bus.mem_rdata : '0;
    assign bus.rsp1_rdata = rsp_rd_en[PORT_DBG] ? bus.mem_rdata : '0;

    assign bus.mem_write   = mem_write_q;
    assign bus.mem_read    = mem_read_q;
    assign bus.mem_address = mem_address_q;
    assign bus.mem_wdata   = mem_wdata_q;
endmodule
